// File: rtl/cam_pkg.sv
// Shared camera types: capture FSM states, RGB565 pixel and default active geometry.
// Used by the DVP capture front end and the downstream sync generator.
package cam_pkg;

    localparam int CAM_H_ACT = 1280;
    localparam int CAM_V_ACT = 720;

    typedef enum logic [1:0] {
        CAP_SKIP   = 2'd0,
        CAP_WAIT   = 2'd1,
        CAP_STREAM = 2'd2
    } cap_state_t;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

endpackage

// File: rtl/dvp_edge.sv
// Two-flop sampler of one DVP control line with rise/fall detect; rise/fall valid 1 clk after the pin.
// No backpressure: free-running every pixel clock.
module dvp_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_d1,
    output logic o_d2,
    output logic o_rise,
    output logic o_fall
);

    logic r_d1;
    logic r_d2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d1 <= 1'b0;
            r_d2 <= 1'b0;
        end else begin
            r_d1 <= i_sig;
            r_d2 <= r_d1;
        end
    end

    assign o_d1   = r_d1;
    assign o_d2   = r_d2;
    assign o_rise = r_d1 & ~r_d2;
    assign o_fall = ~r_d1 & r_d2;

endmodule

// File: rtl/dvp_capture.sv
// DVP byte-pair capture to RGB565 with startup frame skip and line/frame geometry checks.
// Pixel out 2 clk after its second byte at the pins; no backpressure, the sensor cannot be stalled.
module dvp_capture
    import cam_pkg::*;
#(
    parameter int H_ACT       = CAM_H_ACT,
    parameter int V_ACT       = CAM_V_ACT,
    parameter int SKIP_FRAMES = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [7:0]  cam_data,
    input  logic        cam_href,
    input  logic        cam_vsync,
    output logic [15:0] pix_data,
    output logic        pix_valid,
    output logic        out_href,
    output logic        out_vsync,
    output logic        streaming,
    output logic        line_err,
    output logic        frame_err,
    output logic [7:0]  err_cnt
);

    localparam int PW = $clog2(H_ACT + 1);
    localparam int LW = $clog2(V_ACT + 1);
    localparam int SW = $clog2(SKIP_FRAMES + 2);

    logic [7:0]    r_data_d1;
    logic [7:0]    r_hi;
    logic          w_href_d1, w_href_d2, w_href_rise, w_href_fall;
    logic          w_vs_d1_unused, w_vs_d2, w_vs_rise, w_vs_fall_unused;
    cap_state_t    r_state, w_state_nxt;
    logic [SW-1:0] r_skip_cnt;
    logic [PW-1:0] r_pix_cnt;
    logic [LW-1:0] r_line_cnt, w_line_cmp;
    logic          r_phase, w_phase, w_stream, r_first;
    logic          w_line_err, w_frame_err;
    rgb565_t       r_pix;
    logic          r_pix_vld, r_out_href, r_out_vsync, r_line_err, r_frame_err;
    logic [7:0]    r_err_cnt;
    logic [8:0]    w_err_sum;

    dvp_edge u_href_edge (
        .clk    (clk),
        .rst    (rst),
        .i_sig  (cam_href),
        .o_d1   (w_href_d1),
        .o_d2   (w_href_d2),
        .o_rise (w_href_rise),
        .o_fall (w_href_fall)
    );

    dvp_edge u_vsync_edge (
        .clk    (clk),
        .rst    (rst),
        .i_sig  (cam_vsync),
        .o_d1   (w_vs_d1_unused),
        .o_d2   (w_vs_d2),
        .o_rise (w_vs_rise),
        .o_fall (w_vs_fall_unused)
    );

    assign w_stream = (r_state == CAP_STREAM);
    assign w_phase  = w_href_rise ? 1'b0 : r_phase;
    // A line ending in the same cycle as vsync still counts toward this frame.
    assign w_line_cmp = (w_href_fall && (r_line_cnt != {LW{1'b1}})) ? r_line_cnt + 1'b1 : r_line_cnt;
    assign w_err_sum  = {1'b0, r_err_cnt} + {8'd0, w_line_err} + {8'd0, w_frame_err};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= CAP_SKIP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_line_err  = 1'b0;
        w_frame_err = 1'b0;
        case (r_state)
            CAP_SKIP: begin
                if ((r_skip_cnt == SW'(SKIP_FRAMES)) && enable) w_state_nxt = CAP_WAIT;
            end
            CAP_WAIT: begin
                if (w_vs_rise && enable) w_state_nxt = CAP_STREAM;
            end
            CAP_STREAM: begin
                if (w_vs_rise && !enable) w_state_nxt = CAP_WAIT;
                w_line_err  = w_href_fall && ((r_pix_cnt != PW'(H_ACT)) || r_phase);
                w_frame_err = w_vs_rise && !r_first && (w_line_cmp != LW'(V_ACT));
            end
            default: w_state_nxt = CAP_SKIP;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_d1   <= 8'd0;
            r_hi        <= 8'd0;
            r_phase     <= 1'b0;
            r_pix       <= '0;
            r_pix_vld   <= 1'b0;
            r_pix_cnt   <= '0;
            r_line_cnt  <= '0;
            r_skip_cnt  <= '0;
            r_first     <= 1'b0;
            r_out_href  <= 1'b0;
            r_out_vsync <= 1'b0;
            r_line_err  <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_cnt   <= 8'd0;
        end else begin
            r_data_d1 <= cam_data;
            r_pix_vld <= 1'b0;
            if (w_href_d1) begin
                r_phase <= ~w_phase;
                if (!w_phase) begin
                    r_hi <= r_data_d1;
                end else begin
                    r_pix     <= {r_hi, r_data_d1};
                    r_pix_vld <= w_stream;
                    if (r_pix_cnt != {PW{1'b1}}) r_pix_cnt <= r_pix_cnt + 1'b1;
                end
            end
            if (w_href_rise) r_pix_cnt <= '0;
            r_line_cnt <= w_vs_rise ? '0 : w_line_cmp;
            if ((r_state == CAP_SKIP) && w_vs_rise && (r_skip_cnt != SW'(SKIP_FRAMES)))
                r_skip_cnt <= r_skip_cnt + 1'b1;
            // The frame that opens streaming has no trusted predecessor to judge.
            if (!w_stream && (w_state_nxt == CAP_STREAM))
                r_first <= 1'b1;
            else if (w_stream && w_vs_rise)
                r_first <= 1'b0;
            r_out_href  <= w_href_d2 & w_stream;
            r_out_vsync <= w_vs_d2 & w_stream;
            r_line_err  <= w_line_err;
            r_frame_err <= w_frame_err;
            r_err_cnt   <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
        end
    end

    assign pix_data  = r_pix;
    assign pix_valid = r_pix_vld;
    assign out_href  = r_out_href;
    assign out_vsync = r_out_vsync;
    assign streaming = w_stream;
    assign line_err  = r_line_err;
    assign frame_err = r_frame_err;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_dvp_capture.sv
// Directed bench for dvp_capture with small geometry (8 px x 4 lines, skip 2 frames).
module tb_dvp_capture;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int SK = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [7:0]  cam_data;
    logic        cam_href;
    logic        cam_vsync;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        out_href;
    logic        out_vsync;
    logic        streaming;
    logic        line_err;
    logic        frame_err;
    logic [7:0]  err_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    int n_pv = 0, n_le = 0, n_fe = 0, n_oh = 0, n_ov = 0;
    int last_pix = 0;
    int b_pv = 0, b_le = 0, b_fe = 0, b_oh = 0, b_ov = 0;

    dvp_capture #(.H_ACT(H), .V_ACT(V), .SKIP_FRAMES(SK)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .cam_data  (cam_data),
        .cam_href  (cam_href),
        .cam_vsync (cam_vsync),
        .pix_data  (pix_data),
        .pix_valid (pix_valid),
        .out_href  (out_href),
        .out_vsync (out_vsync),
        .streaming (streaming),
        .line_err  (line_err),
        .frame_err (frame_err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    // Output event counters, sampled just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (pix_valid) begin
            n_pv     <= n_pv + 1;
            last_pix <= int'(pix_data);
        end
        if (line_err)  n_le <= n_le + 1;
        if (frame_err) n_fe <= n_fe + 1;
        if (out_href)  n_oh <= n_oh + 1;
        if (out_vsync) n_ov <= n_ov + 1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk = n_chk + 1;
        if (got == exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    task automatic mark();
        b_pv = n_pv; b_le = n_le; b_fe = n_fe; b_oh = n_oh; b_ov = n_ov;
    endtask

    task automatic cyc(input logic [7:0] d, input logic h, input logic v);
        cam_data  = d;
        cam_href  = h;
        cam_vsync = v;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(8'h00, 1'b0, 1'b0);
    endtask

    task automatic vs_pulse();
        cyc(8'h00, 1'b0, 1'b1);
        cyc(8'h00, 1'b0, 1'b1);
        idle(4);
    endtask

    task automatic line(input int nbytes);
        for (int k = 0; k < nbytes; k++) cyc(8'(k), 1'b1, 1'b0);
        idle(4);
    endtask

    task automatic frame(input int nlines);
        vs_pulse();
        for (int k = 0; k < nlines; k++) line(2 * H);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        enable    = 1'b1;
        cam_data  = 8'h00;
        cam_href  = 1'b0;
        cam_vsync = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pix_valid", int'(pix_valid), 0);
        chk("rst_pix_data",  int'(pix_data),  0);
        chk("rst_out_href",  int'(out_href),  0);
        chk("rst_out_vsync", int'(out_vsync), 0);
        chk("rst_streaming", int'(streaming), 0);
        chk("rst_errs",      int'({line_err, frame_err}), 0);
        chk("rst_err_cnt",   int'(err_cnt),   0);
        rst = 1'b0;
        idle(2);

        // Two frames discarded, third vsync opens streaming
        mark();
        frame(V);
        frame(V);
        chk("skip_pix",    n_pv - b_pv, 0);
        chk("skip_href",   n_oh - b_oh, 0);
        chk("skip_stream", int'(streaming), 0);
        mark();
        vs_pulse();
        chk("stream_on",  int'(streaming), 1);
        chk("ovsync_len", n_ov - b_ov, 2);

        // First line carries 0xAB,0xCD to check latency and alignment
        mark();
        for (int i = 0; i < 2 * H; i++) begin
            cyc((i == 0) ? 8'hAB : ((i == 1) ? 8'hCD : 8'(i)), 1'b1, 1'b0);
            if (i == 1) chk("lat_early", int'(pix_valid), 0);
            if (i == 2) begin
                chk("lat_valid", int'(pix_valid), 1);
                chk("lat_data",  int'(pix_data), 'hABCD);
                chk("lat_href",  int'(out_href), 1);
            end
            if (i == 3) chk("lat_strobe", int'(pix_valid), 0);
        end
        idle(4);
        for (int k = 0; k < V - 1; k++) line(2 * H);
        chk("f3_pix",      n_pv - b_pv, 32);
        chk("f3_href_cyc", n_oh - b_oh, 64);
        chk("f3_last_pix", last_pix, 'h0E0F);
        chk("f3_line_err", n_le - b_le, 0);

        // Odd-length line
        mark();
        vs_pulse();
        chk("f3_frame_err", n_fe - b_fe, 0);
        mark();
        line(15);
        chk("odd_pix",      n_pv - b_pv, 7);
        chk("odd_line_err", n_le - b_le, 1);
        chk("odd_err_cnt",  int'(err_cnt), 1);
        for (int k = 0; k < V - 1; k++) line(2 * H);

        // Short frame (3 lines) flagged at the next vsync
        mark();
        frame(V - 1);
        chk("f4_frame_err", n_fe - b_fe, 0);
        mark();
        vs_pulse();
        chk("short_frame_err", n_fe - b_fe, 1);
        chk("short_err_cnt",   int'(err_cnt), 2);

        // Enable dropped mid-frame: frame completes, then WAIT
        mark();
        line(2 * H);
        line(2 * H);
        enable = 1'b0;
        line(2 * H);
        line(2 * H);
        chk("drain_pix", n_pv - b_pv, 32);
        mark();
        vs_pulse();
        chk("wait_stream", int'(streaming), 0);
        line(2 * H);
        chk("wait_pix",       n_pv - b_pv, 0);
        chk("wait_href",      n_oh - b_oh, 0);
        chk("wait_vsync",     n_ov - b_ov, 0);
        chk("wait_frame_err", n_fe - b_fe, 0);

        // Re-enter streaming: first short frame is not judged, the second is
        enable = 1'b1;
        vs_pulse();
        chk("restream", int'(streaming), 1);
        for (int k = 0; k < V - 1; k++) line(2 * H);
        mark();
        vs_pulse();
        chk("first_frame_supp", n_fe - b_fe, 0);
        chk("supp_err_cnt",     int'(err_cnt), 2);
        for (int k = 0; k < V - 1; k++) line(2 * H);
        mark();
        vs_pulse();
        chk("second_frame_err", n_fe - b_fe, 1);
        chk("second_err_cnt",   int'(err_cnt), 3);

        // Reset in the middle of a line
        for (int i = 0; i < 5; i++) cyc(8'(i + 1), 1'b1, 1'b0);
        rst = 1'b1;
        cyc(8'h55, 1'b1, 1'b0);
        chk("midrst_pix_valid", int'(pix_valid), 0);
        chk("midrst_pix_data",  int'(pix_data), 0);
        chk("midrst_out_href",  int'(out_href), 0);
        chk("midrst_streaming", int'(streaming), 0);
        chk("midrst_err_cnt",   int'(err_cnt), 0);
        cyc(8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        idle(2);
        mark();
        frame(V);
        frame(V);
        chk("reskip_pix",    n_pv - b_pv, 0);
        chk("reskip_stream", int'(streaming), 0);
        vs_pulse();
        chk("reskip_on", int'(streaming), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
